fairy_trace_buffer: RTL and testbench
=====================================

// Module: fairy_trace_buffer
// PURPOSE
//  Parametrised debug trace capture for the fairy pipeline. Replaces fixed debug wiring with a
//  selectable NUM_CH-channel probe bus and a DEPTH-entry circular trace RAM. Each retired
//  instruction (probe_valid_i) records {pc, selected channel}. Capture stops a programmable
//  number of samples after a PC-match or forced trigger. The result is read back by index.
//  Instantiated in fairy_top beside the writeback stage.
// PARAMETERS
//  NUM_CH   16  number of DATA_W-bit probe channels on probe_i
//  DATA_W   32  width of one probe channel
//  DEPTH    64  trace entries; power of two, >= 4
//  AW       $clog2(DEPTH)  entry index width (localparam)
//  SW       $clog2(NUM_CH) channel select width (localparam)
// PORTS
//  aclk           in   1              clock
//  areset_n       in   1              asynchronous reset, active low
//  probe_i        in   NUM_CH*DATA_W  probe bus; channel k = probe_i[k*DATA_W +: DATA_W]
//  probe_valid_i  in   1              sample strobe (one retired instruction)
//  pc_i           in   32             PC of the retiring instruction
//  cap_sel_i      in   SW             channel to record; latched on arm
//  arm_i          in   1              start or restart capture (pulse)
//  abort_i        in   1              return to IDLE (pulse)
//  force_trig_i   in   1              unconditional trigger on the next valid sample
//  trig_en_i      in   1              enable PC-match trigger
//  trig_pc_i      in   32             trigger PC
//  post_cnt_i     in   AW             samples after the trigger sample; latched on arm
//  rd_idx_i       in   AW             read index, 0 = oldest stored entry
//  rd_data_o      out  32+DATA_W      {pc, data} at rd_idx_i; 1-cycle registered
//  rd_valid_o     out  1              rd_data_o holds a stored entry
//  state_o        out  2              0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  count_o        out  AW+1           stored entries, saturates at DEPTH
//  trig_idx_o     out  AW             index of the trigger entry, relative to oldest
//  triggered_o    out  1              trigger has occurred in this capture
// BEHAVIOUR
//  - Reset (async, areset_n=0)
//    - all outputs 0; state IDLE; wr_ptr and remaining counter 0.
//    - Trace RAM is not reset. With count 0, every read is invalid.
//  - Priority per cycle: abort_i > arm_i > trigger/write.
//    - abort_i: any state -> IDLE; count and trace contents are kept.
//  - IDLE / DONE
//    - No writes.
//    - arm_i -> ARMED: clear wr_ptr, count, triggered_o.
//    - On arm, latch cap_sel_i and post_cnt_i clamped to DEPTH-1, so the trigger entry is never overwritten.
//  - ARMED
//    - Each probe_valid_i writes {pc_i, probe ch[cap_sel]} at wr_ptr.
//    - wr_ptr increments mod DEPTH; count increments, saturating at DEPTH.
//    - Trigger = probe_valid_i & (force_trig_i | (trig_en_i & pc_i==trig_pc_i)).
//    - On trigger: the sample is written and trig_ptr <= wr_ptr; triggered_o <= 1.
//    - On trigger: remaining <= post_cnt. If post_cnt==0 -> DONE, else -> POST.
//    - arm_i in ARMED restarts capture (same as from IDLE).
//  - POST
//    - Each valid sample is written and remaining decrements.
//    - The write made with remaining==1 -> DONE in the same edge.
//    - Triggers in POST are ignored.
//  - No valid sample in a cycle: no write, no count change, no state change.
//  - Read path
//    - oldest = (count==DEPTH) ? wr_ptr : 0.
//    - Address = (oldest + rd_idx_i) mod DEPTH.
//    - rd_valid_o <= (rd_idx_i < count). rd_data_o <= RAM[addr] if valid, else 0.
//    - Reading in the same cycle as a write to the same address returns the old data.
//    - Reads are legal in every state. Readout while ARMED/POST is non-coherent but defined.
//  - trig_idx_o = (trig_ptr - oldest) mod DEPTH, registered; meaningful when triggered_o=1.
//  - All counters wrap/saturate as stated; no X on any output after reset.
// TESTING
//  T1
//    - Stimulus: reset; DEPTH=64; arm, cap_sel=3; 10 samples with pc=0x100+4i;
//      sample 5 forced as trigger; post_cnt=2.
//    - Response: DONE after sample 7; count=8; trig_idx=5;
//      rd_idx 0..7 give pc 0x100..0x11C and ch3 data; rd_idx 8 gives rd_valid=0.
//  T2
//    - Stimulus: trig_pc=0x400; 100 samples with pc=4i (match at i=256? no: i=100 absent),
//      then sample pc=0x400; post_cnt=0.
//    - Response: DONE immediately; count=64; trig_idx=63; oldest entry is the 37th sample (wrap).
//  T3
//    - Stimulus: post_cnt=63 (DEPTH-1) vs 70 truncated.
//    - Response: clamped; trigger entry survives at trig_idx=0 when the trigger is sample 0.
//  T4
//    - Stimulus: arm and abort asserted in the same cycle while in POST.
//    - Response: state IDLE; next arm restarts with count 0.
//  T5
//    - Stimulus: areset_n low mid-POST.
//    - Response: state 0, count 0, rd_valid 0 immediately (async); capture works after re-arm.

Source files
------------

// File: rtl/fairy_trace_buffer.sv
// fairy_trace_buffer: selectable-channel debug trace capture into a circular RAM with PC/forced trigger
module fairy_trace_buffer #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int SW = $clog2(NUM_CH)
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic [NUM_CH*DATA_W-1:0] probe_i,
    input  logic                     probe_valid_i,
    input  logic [31:0]              pc_i,
    input  logic [SW-1:0]            cap_sel_i,
    input  logic                     arm_i,
    input  logic                     abort_i,
    input  logic                     force_trig_i,
    input  logic                     trig_en_i,
    input  logic [31:0]              trig_pc_i,
    input  logic [AW-1:0]            post_cnt_i,
    input  logic [AW-1:0]            rd_idx_i,
    output logic [32+DATA_W-1:0]     rd_data_o,
    output logic                     rd_valid_o,
    output logic [1:0]               state_o,
    output logic [AW:0]              count_o,
    output logic [AW-1:0]            trig_idx_o,
    output logic                     triggered_o
);
    localparam int EW = 32 + DATA_W;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] POST  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [EW-1:0]     mem [DEPTH];
    logic [DATA_W-1:0] chans [NUM_CH];
    logic [DATA_W-1:0] ch;
    logic [1:0]        state;
    logic [AW-1:0]     wr_ptr, trig_ptr, remaining, post, oldest, rd_addr;
    logic [AW:0]       count;
    logic [SW-1:0]     sel;
    logic              triggered, active, wr_en, trig, full, rd_ok;

    assign state_o     = state;
    assign count_o     = count;
    assign triggered_o = triggered;

    // Channel mux, write qualification, trigger detect and oldest-relative read addressing
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) chans[k] = probe_i[k*DATA_W +: DATA_W];
        ch      = chans[sel];
        active  = (state == ARMED) || (state == POST);
        wr_en   = probe_valid_i && active && !abort_i && !arm_i;
        trig    = probe_valid_i && (force_trig_i || (trig_en_i && pc_i == trig_pc_i));
        full    = count == FULL;
        oldest  = full ? wr_ptr : '0;
        rd_addr = oldest + rd_idx_i;
        rd_ok   = {1'b0, rd_idx_i} < count;
    end

    // Capture control: abort beats arm beats trigger/write; post_cnt_i is AW bits so it never exceeds DEPTH-1
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            trig_ptr  <= '0;
            remaining <= '0;
            post      <= '0;
            sel       <= '0;
            triggered <= 1'b0;
        end else if (abort_i) begin
            state <= IDLE;
        end else if (arm_i) begin
            state     <= ARMED;
            wr_ptr    <= '0;
            count     <= '0;
            triggered <= 1'b0;
            sel       <= cap_sel_i;
            post      <= post_cnt_i;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= full ? count : count + 1'b1;
            if (state == ARMED && trig) begin
                trig_ptr  <= wr_ptr;
                triggered <= 1'b1;
                remaining <= post;
                state     <= (post == '0) ? DONE : POST;
            end else if (state == POST) begin
                remaining <= remaining - 1'b1;
                if (remaining == AW'(1)) state <= DONE;
            end
        end
    end

    // Trace RAM write port; left unreset so it maps onto block RAM
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {pc_i, ch};
    end

    // Registered readout and trigger position; a same-edge write leaves the old word visible
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            trig_idx_o <= '0;
        end else begin
            rd_valid_o <= rd_ok;
            rd_data_o  <= rd_ok ? mem[rd_addr] : '0;
            trig_idx_o <= trig_ptr - oldest;
        end
    end
endmodule

// File: tb/tb_fairy_trace_buffer.sv
// tb_fairy_trace_buffer: directed and table-driven checks of capture, trigger, wrap, abort and reset
module tb_fairy_trace_buffer;
    localparam int NUM_CH = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int SW     = 4;

    logic                     aclk = 1'b0;
    logic                     areset_n = 1'b1;
    logic [NUM_CH*DATA_W-1:0] probe_i = '0;
    logic                     probe_valid_i = 1'b0;
    logic [31:0]              pc_i = '0;
    logic [SW-1:0]            cap_sel_i = '0;
    logic                     arm_i = 1'b0;
    logic                     abort_i = 1'b0;
    logic                     force_trig_i = 1'b0;
    logic                     trig_en_i = 1'b0;
    logic [31:0]              trig_pc_i = '0;
    logic [AW-1:0]            post_cnt_i = '0;
    logic [AW-1:0]            rd_idx_i = '0;
    logic [32+DATA_W-1:0]     rd_data_o;
    logic                     rd_valid_o;
    logic [1:0]               state_o;
    logic [AW:0]              count_o;
    logic [AW-1:0]            trig_idx_o;
    logic                     triggered_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] idx;
        logic          v;
        logic [31:0]   pc;
        logic [31:0]   d;
    } rd_vec_t;

    rd_vec_t tbl [10];

    fairy_trace_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset_n(areset_n), .probe_i(probe_i), .probe_valid_i(probe_valid_i),
        .pc_i(pc_i), .cap_sel_i(cap_sel_i), .arm_i(arm_i), .abort_i(abort_i),
        .force_trig_i(force_trig_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
        .post_cnt_i(post_cnt_i), .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .state_o(state_o), .count_o(count_o),
        .trig_idx_o(trig_idx_o), .triggered_o(triggered_o)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] dat(int k, int i);
        return 32'hC000_0000 | 32'(k << 16) | 32'(i);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic arm(logic [SW-1:0] s, logic [AW-1:0] p);
        cap_sel_i  = s;
        post_cnt_i = p;
        arm_i      = 1'b1;
        step();
        arm_i      = 1'b0;
    endtask

    task automatic drive(int i, logic [31:0] pc, logic f);
        for (int k = 0; k < NUM_CH; k++) probe_i[k*DATA_W +: DATA_W] = dat(k, i);
        pc_i          = pc;
        force_trig_i  = f;
        probe_valid_i = 1'b1;
        step();
        probe_valid_i = 1'b0;
        force_trig_i  = 1'b0;
    endtask

    task automatic check_read(string name, logic [AW-1:0] idx, logic v, logic [31:0] pc, logic [31:0] d);
        rd_idx_i = idx;
        step();
        chk({name, "_valid"}, 64'(rd_valid_o), 64'(v));
        chk({name, "_data"}, rd_data_o, v ? {pc, d} : 64'h0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{AW'(i), 1'b1, 32'h100 + 32'(4 * i), dat(3, i)};
        tbl[8] = '{6'd8, 1'b0, 32'h0, 32'h0};
        tbl[9] = '{6'd63, 1'b0, 32'h0, 32'h0};

        #2 areset_n = 1'b0;
        #10;
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_trig", 64'(triggered_o), 64'd0);
        chk("rst_rdv", 64'(rd_valid_o), 64'd0);
        chk("rst_rdd", rd_data_o, 64'h0);
        chk("rst_tidx", 64'(trig_idx_o), 64'd0);
        step();
        areset_n = 1'b1;
        step();
        check_read("empty_rd", 6'd0, 1'b0, 32'h0, 32'h0);

        // T1: forced trigger at sample 5, two post samples
        arm(4'd3, 6'd2);
        chk("t1_armed", 64'(state_o), 64'd1);
        force_trig_i = 1'b1;
        step();
        force_trig_i = 1'b0;
        chk("t1_noval_state", 64'(state_o), 64'd1);
        chk("t1_noval_count", 64'(count_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            drive(i, 32'h100 + 32'(4 * i), i == 5);
            if (i == 5) chk("t1_post", 64'(state_o), 64'd2);
            if (i == 6) chk("t1_post2", 64'(state_o), 64'd2);
            if (i == 7) chk("t1_done", 64'(state_o), 64'd3);
        end
        chk("t1_count", 64'(count_o), 64'd8);
        chk("t1_trig", 64'(triggered_o), 64'd1);
        for (int i = 0; i < 10; i++) check_read("t1_rd", tbl[i].idx, tbl[i].v, tbl[i].pc, tbl[i].d);
        chk("t1_tidx", 64'(trig_idx_o), 64'd5);

        // T2: PC-match trigger after wrap, post 0
        trig_en_i = 1'b1;
        trig_pc_i = 32'h400;
        arm(4'd0, 6'd0);
        for (int i = 0; i < 100; i++) drive(i, 32'(4 * i), 1'b0);
        chk("t2_noearly", 64'(state_o), 64'd1);
        drive(100, 32'h400, 1'b0);
        chk("t2_done", 64'(state_o), 64'd3);
        chk("t2_count", 64'(count_o), 64'd64);
        check_read("t2_oldest", 6'd0, 1'b1, 32'h94, dat(0, 37));
        check_read("t2_trigent", 6'd63, 1'b1, 32'h400, dat(0, 100));
        check_read("t2_prev", 6'd62, 1'b1, 32'h18C, dat(0, 99));
        chk("t2_tidx", 64'(trig_idx_o), 64'd63);
        trig_en_i = 1'b0;

        // T3: maximum post count keeps the trigger entry; 70 truncates to 6
        arm(4'd15, 6'd63);
        drive(0, 32'h1000, 1'b1);
        for (int i = 1; i < 64; i++) begin
            drive(i, 32'h1000 + 32'(4 * i), 1'b0);
            if (i == 62) chk("t3_post", 64'(state_o), 64'd2);
        end
        chk("t3_done", 64'(state_o), 64'd3);
        chk("t3_count", 64'(count_o), 64'd64);
        check_read("t3_trigent", 6'd0, 1'b1, 32'h1000, dat(15, 0));
        chk("t3_tidx", 64'(trig_idx_o), 64'd0);
        begin
            logic [6:0] big;
            big = 7'd70;
            arm(4'd15, big[5:0]);
        end
        for (int i = 0; i < 9; i++) drive(i, 32'h2000 + 32'(4 * i), i == 0);
        chk("t3_trunc_count", 64'(count_o), 64'd7);
        chk("t3_trunc_state", 64'(state_o), 64'd3);

        // T4: abort and arm together in POST
        arm(4'd1, 6'd5);
        drive(0, 32'h10, 1'b1);
        drive(1, 32'h14, 1'b0);
        chk("t4_post", 64'(state_o), 64'd2);
        arm_i = 1'b1;
        abort_i = 1'b1;
        probe_valid_i = 1'b1;
        step();
        arm_i = 1'b0;
        abort_i = 1'b0;
        probe_valid_i = 1'b0;
        chk("t4_idle", 64'(state_o), 64'd0);
        chk("t4_kept", 64'(count_o), 64'd2);
        check_read("t4_keptrd", 6'd1, 1'b1, 32'h14, dat(1, 1));
        arm(4'd1, 6'd5);
        chk("t4_rearm", 64'(state_o), 64'd1);
        chk("t4_clr", 64'(count_o), 64'd0);
        chk("t4_trigclr", 64'(triggered_o), 64'd0);

        // T5: async reset mid-POST
        arm(4'd2, 6'd4);
        drive(0, 32'h200, 1'b1);
        drive(1, 32'h204, 1'b0);
        rd_idx_i = 6'd0;
        step();
        chk("t5_pre_rdv", 64'(rd_valid_o), 64'd1);
        #2 areset_n = 1'b0;
        #1;
        chk("t5_state", 64'(state_o), 64'd0);
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_rdv", 64'(rd_valid_o), 64'd0);
        chk("t5_trig", 64'(triggered_o), 64'd0);
        step();
        areset_n = 1'b1;
        arm(4'd2, 6'd0);
        drive(0, 32'h300, 1'b1);
        chk("t5_done", 64'(state_o), 64'd3);
        chk("t5_count1", 64'(count_o), 64'd1);
        check_read("t5_rd", 6'd0, 1'b1, 32'h300, dat(2, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
